reg_writeback: RTL
==================

# reg_writeback

Writeback initiator for the 32-entry register file: the single block that drives the register-file write port. It merges ALU results and in-order memory load responses into one registered write per cycle, tracks destination registers of outstanding loads in a small in-order FIFO, and exports a per-register busy scoreboard so the instruction decoder can stall on load-use hazards. It sits between the ALU/data-memory response path and the register file's write inputs.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers
- AW, 5, register index width
- LD_DEPTH, 2, maximum outstanding loads (rd FIFO depth, power of 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- ld_issue  in  1  load sent to memory this cycle
- ld_rd  in  AW  destination of issued load
- ld_issue_ready  out  1  FIFO has space (registered count < LD_DEPTH)
- ld_valid  in  1  load data returned (in order)
- ld_data  in  XLEN  load data
- rf_we  out  1  register-file write enable
- rf_rd  out  AW  register-file write index
- rf_data  out  XLEN  register-file write data
- busy  out  NREG  scoreboard; bit r = load to r outstanding
- err  out  1  sticky: ld_valid received with empty FIFO

## Operation
- Per cycle, at most one write source wins: load response (ld_valid with FIFO non-empty) has priority; otherwise ALU (alu_valid).
- alu_ready = alu_valid and not winning load response; ALU holds inputs stable while alu_ready=0.
- Winner registered into rf_we/rf_rd/rf_data; load winner pops FIFO head for rf_rd.
- Writes with rd=0 are consumed (ready/pop normally) but produce rf_we=0; x0 never written.
- ld_issue pushes ld_rd into FIFO; ld_issue while ld_issue_ready=0 is ignored (no push, no busy change).
- busy[r] set on accepted ld_issue with ld_rd=r, r≠0; cleared when a load for r pops and no other FIFO entry still targets r. Same-cycle set and clear of same r: set wins.
- ALU writes never modify busy; decoder guarantees no ALU write to a busy register.
- ld_valid with empty FIFO: no write, no pop, err set and held until rst.
- busy[0] always 0.

## Timing
- Reset (rst=1 at edge): rf_we=0, rf_rd=0, rf_data=0, busy=0, err=0, FIFO empty, ld_issue_ready=1 after the edge. Reset mid-operation discards outstanding loads and pending writes.
- Latency: input accepted in cycle N → rf_we/rf_rd/rf_data valid in cycle N+1, held exactly one cycle (rf_we low in N+2 unless new write).
- Throughput: one write per cycle.
- ld_issue and ld_valid in same cycle: pop uses pre-push head; response in same cycle as its own issue is illegal (FIFO empty → err).
- Full FIFO with simultaneous pop: ld_issue_ready stays 0 that cycle (based on registered count); push accepted next cycle.
- busy updates visible the cycle after the event; rd pointers wrap modulo LD_DEPTH.

## Structure
- Package wb_pkg: XLEN, AW, NREG, LD_DEPTH constants; write-source enum (SRC_NONE, SRC_ALU, SRC_LD).
- One sub-module: wb_rd_fifo (LD_DEPTH x AW, push/pop/count, registered full/empty); scoreboard, arbitration and output register in reg_writeback.

## Test plan
- Reset: rst=1 for 2 cycles with alu_valid=1 → rf_we=0, busy=0, err=0; after release alu_rd=3,alu_data=0x55 → next cycle rf_we=1,rf_rd=3,rf_data=0x55.
- Conflict: ld_issue rd=5; next cycle ld_valid data=0xDEAD with alu_valid rd=7 → alu_ready=0, write (5,0xDEAD); following cycle write (7,ALU data), busy[5] 1→0.
- Capacity: two ld_issue (rd=4, rd=6) → ld_issue_ready=0, third issue ignored; responses write 4 then 6 in order, busy clears each.
- Same rd twice: issue rd=9 twice, first response → busy[9] stays 1; second → busy[9]=0.
- x0: alu_rd=0 and load rd=0 → consumed, rf_we=0, busy[0]=0.
- Spurious: ld_valid with empty FIFO → no write, err=1 until rst.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback path.
package wb_pkg;
  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int LD_DEPTH = 2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_e;
endpackage

// File: rtl/wb_rd_fifo.sv
// In-order FIFO of outstanding load destinations, with a per-slot view
// so the owner can rebuild its busy scoreboard from the surviving entries.
module wb_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0][W-1:0]   slot_rd,
  output logic [DEPTH-1:0]          slot_keep
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_d;
  logic [DEPTH-1:0] vld;
  logic [W-1:0]   mem [DEPTH];
  logic           push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count_d = count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // NOTE: storage is not reset; the valid bits and count alone decide which
  // slots are meaningful, so resetting the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_rd[i]   = mem[i];
      slot_keep[i] = vld[i] && !(pop_ok && (rd_ptr == PW'(i)));
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port owner: arbitrates load responses over ALU results,
// registers one write per cycle and exports the load-use busy scoreboard.
module reg_writeback #(
  parameter int XLEN     = wb_pkg::XLEN,
  parameter int NREG     = wb_pkg::NREG,
  parameter int AW       = wb_pkg::AW,
  parameter int LD_DEPTH = wb_pkg::LD_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  output logic            ld_issue_ready,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [NREG-1:0] busy,
  output logic            err
);
  import wb_pkg::*;

  logic                        fifo_full, fifo_empty;
  logic [AW-1:0]               fifo_head;
  logic [LD_DEPTH-1:0][AW-1:0] slot_rd;
  logic [LD_DEPTH-1:0]         slot_keep;
  logic                        ld_win, push, wr_en;
  wb_src_e                     src;
  logic [AW-1:0]               wr_rd;
  logic [XLEN-1:0]             wr_data;
  logic [NREG-1:0]             busy_d;

  wb_rd_fifo #(.DEPTH(LD_DEPTH), .W(AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (ld_win),
    .din       (ld_rd),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .slot_rd   (slot_rd),
    .slot_keep (slot_keep)
  );

  assign ld_issue_ready = !fifo_full;
  assign push           = ld_issue && !fifo_full;
  assign ld_win         = ld_valid && !fifo_empty;
  assign alu_ready      = alu_valid && !ld_win;
  assign wr_en          = (src != SRC_NONE) && (wr_rd != '0);

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    src     = SRC_NONE;
    wr_rd   = '0;
    wr_data = '0;
    if (ld_win) begin
      src     = SRC_LD;
      wr_rd   = fifo_head;
      wr_data = ld_data;
    end else if (alu_valid) begin
      src     = SRC_ALU;
      wr_rd   = alu_rd;
      wr_data = alu_data;
    end
  end

  // Busy is rebuilt from the entries that survive this cycle plus any push,
  // which gives repeated destinations and same-cycle set-over-clear for free.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (slot_keep[i]) busy_d[slot_rd[i]] = 1'b1;
    end
    if (push) busy_d[ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      busy    <= '0;
      err     <= 1'b0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_rd   <= wr_rd;
        rf_data <= wr_data;
      end
      busy <= busy_d;
      if (ld_valid && fifo_empty) err <= 1'b1;
    end
  end
endmodule
